// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter: the owner-tag bit positions,
// the arbitration state encoding and the wait-counter width helper.
package vram_pkg;

    localparam int OWN_VID = 0;
    localparam int OWN_CPU = 1;

    typedef enum logic {
        VPRIO  = 1'b0,
        CFORCE = 1'b1
    } state_t;

    // Holds 0..max; at least one bit so that max = 0 still gives a legal vector.
    function automatic int ctr_width(input int max);
        return (max < 2) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/vram_starve_ctr.sv
// Counts consecutive cycles of an unserved CPU request, saturating at MAX.
// at_max flags the edge at which the count reaches MAX.
module vram_starve_ctr #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic served,
    output logic at_max
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    // A grant or a withdrawn request both restart the wait.
    always_comb begin
        if (served || !waiting) begin
            cnt_nxt = '0;
        end else if (cnt == W'(MAX)) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Looking at the next value lets the forced slot land on the cycle right
    // after MAX unserved cycles instead of one cycle later.
    assign at_max = waiting && !served && (cnt_nxt == W'(MAX));

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Two-requester arbiter for a single-port VRAM: video has fixed priority,
// a starvation guard forces a CPU slot, and read data returns one cycle after grant.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int A        = 10,
    parameter int D        = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         vid_req,
    input  logic [A-1:0] vid_addr,
    output logic         vid_gnt,
    output logic         vid_rvalid,
    output logic [D-1:0] vid_rdata,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [A-1:0] cpu_addr,
    input  logic [D-1:0] cpu_wdata,
    output logic         cpu_gnt,
    output logic         cpu_rvalid,
    output logic [D-1:0] cpu_rdata,
    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout
);

    localparam int CW = ctr_width(MAX_WAIT);

    state_t     state;
    logic [1:0] owner_q;
    logic       at_max;

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        vid_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!reset) begin
            case (state)
                CFORCE: begin
                    cpu_gnt = cpu_req;
                    vid_gnt = vid_req & ~cpu_req;
                end
                default: begin
                    vid_gnt = vid_req;
                    cpu_gnt = cpu_req & ~vid_req;
                end
            endcase
        end
    end

    assign ram_addr = cpu_gnt ? cpu_addr  : vid_addr;
    assign ram_din  = cpu_gnt ? cpu_wdata : '0;
    assign ram_we   = cpu_gnt & cpu_we;

    vram_starve_ctr #(
        .W   (CW),
        .MAX (MAX_WAIT)
    ) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .waiting (cpu_req & ~cpu_gnt),
        .served  (cpu_gnt),
        .at_max  (at_max)
    );

    // The forced CPU slot lasts one cycle whether or not the CPU still wants it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= VPRIO;
            owner_q <= '0;
        end else begin
            case (state)
                VPRIO: begin
                    if (MAX_WAIT != 0 && cpu_req && at_max) begin
                        state <= CFORCE;
                    end
                end
                default: state <= VPRIO;
            endcase
            owner_q[OWN_VID] <= vid_gnt;
            owner_q[OWN_CPU] <= cpu_gnt & ~cpu_we;
        end
    end

    assign vid_rvalid = owner_q[OWN_VID];
    assign cpu_rvalid = owner_q[OWN_CPU];
    assign vid_rdata  = ram_dout;
    assign cpu_rdata  = ram_dout;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a guarded instance (MAX_WAIT=15) with a
// scoreboarded VRAM model, plus an unguarded instance (MAX_WAIT=0) on the same inputs.
module tb_vram_arbiter;

    localparam int A = 10;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         vid_req = 1'b0;
    logic [A-1:0] vid_addr = '0;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [A-1:0] cpu_addr = '0;
    logic [D-1:0] cpu_wdata = '0;

    logic         vid_gnt, vid_rvalid, cpu_gnt, cpu_rvalid, ram_we;
    logic [D-1:0] vid_rdata, cpu_rdata, ram_din, ram_dout;
    logic [A-1:0] ram_addr;

    logic         vid_gnt_z, vid_rvalid_z, cpu_gnt_z, cpu_rvalid_z, ram_we_z;
    logic [D-1:0] vid_rdata_z, cpu_rdata_z, ram_din_z, ram_dout_z;
    logic [A-1:0] ram_addr_z;

    logic [D-1:0] mem   [0:(1<<A)-1];
    logic [D-1:0] mem_z [0:(1<<A)-1];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [D-1:0] data;
        int           due;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM models: registered read of the pre-edge contents, write on the edge.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (ram_we_z) mem_z[ram_addr_z] <= ram_din_z;
        ram_dout_z <= mem_z[ram_addr_z];
    end

    vram_arbiter #(.A(A), .D(D), .MAX_WAIT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt),
        .vid_rvalid (vid_rvalid),
        .vid_rdata  (vid_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout)
    );

    vram_arbiter #(.A(A), .D(D), .MAX_WAIT(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_gnt    (vid_gnt_z),
        .vid_rvalid (vid_rvalid_z),
        .vid_rdata  (vid_rdata_z),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt_z),
        .cpu_rvalid (cpu_rvalid_z),
        .cpu_rdata  (cpu_rdata_z),
        .ram_addr   (ram_addr_z),
        .ram_din    (ram_din_z),
        .ram_we     (ram_we_z),
        .ram_dout   (ram_dout_z)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_vid(input logic [D-1:0] d);
        vid_q.push_back('{d, cyc + 1});
    endtask

    task automatic exp_cpu(input logic [D-1:0] d);
        cpu_q.push_back('{d, cyc + 1});
    endtask

    // Monitor: every rvalid must match the oldest expectation, on its due cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (vid_rvalid) begin
                if (vid_q.size() == 0) begin
                    check("vid_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = vid_q.pop_front();
                    check("vid_rdata", vid_rdata, e.data);
                    check("vid_latency", cyc, e.due);
                end
            end
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    check("cpu_rdata", cpu_rdata, e.data);
                    check("cpu_latency", cyc, e.due);
                end
            end
        end
    end

    // Video held, CPU read pending from the first cycle: forced slot on cycle 15.
    task automatic starve(input string tag);
        vid_req  = 1'b1;
        vid_addr = 10'h010;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h3FF;
        for (int k = 0; k < 20; k++) begin
            if (k == 16) cpu_req = 1'b0;
            @(negedge clk);
            check({tag, "_cpu_gnt"}, cpu_gnt, (k == 15) ? 32'd1 : 32'd0);
            check({tag, "_vid_gnt"}, vid_gnt, (k == 15) ? 32'd0 : 32'd1);
            if (k <= 15) check({tag, "_nowait_cpu_gnt"}, cpu_gnt_z, 32'd0);
            if (k == 15) exp_cpu(8'hA5);
            else exp_vid(8'h5A);
            tick();
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        for (int i = 0; i < (1 << A); i++) begin
            mem[i]   = '0;
            mem_z[i] = '0;
        end
        mem[10'h010] = 8'h5A;
        mem[10'h020] = 8'h11;
        for (int i = 0; i < 4; i++) mem[10'h100 + i] = 8'hC0 + 8'(i);

        // Reset blocks all grants and writes.
        tick();
        tick();
        vid_req = 1'b1;
        cpu_req = 1'b1;
        cpu_we  = 1'b1;
        @(negedge clk);
        check("rst_vid_gnt", vid_gnt, 32'd0);
        check("rst_cpu_gnt", cpu_gnt, 32'd0);
        check("rst_ram_we", ram_we, 32'd0);
        tick();
        vid_req = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tick();
        reset = 1'b0;

        // Idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_gnt", {vid_gnt, cpu_gnt}, 32'd0);
            check("idle_ram_we", ram_we, 32'd0);
            check("idle_rvalid", {vid_rvalid, cpu_rvalid}, 32'd0);
            tick();
        end

        // Video read latency.
        vid_req  = 1'b1;
        vid_addr = 10'h010;
        @(negedge clk);
        check("vrd_vid_gnt", vid_gnt, 32'd1);
        check("vrd_cpu_gnt", cpu_gnt, 32'd0);
        check("vrd_ram_addr", ram_addr, 32'h010);
        check("vrd_ram_we", ram_we, 32'd0);
        exp_vid(8'h5A);
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        check("vrd_cpu_rvalid", cpu_rvalid, 32'd0);
        tick();

        // CPU write then read.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h3FF;
        cpu_wdata = 8'hA5;
        @(negedge clk);
        check("cwr_cpu_gnt", cpu_gnt, 32'd1);
        check("cwr_ram_we", ram_we, 32'd1);
        check("cwr_ram_addr", ram_addr, 32'h3FF);
        check("cwr_ram_din", ram_din, 32'hA5);
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clk);
        check("cwr_ram_we_after", ram_we, 32'd0);
        check("cwr_no_rvalid", cpu_rvalid, 32'd0);
        tick();
        cpu_req = 1'b1;
        @(negedge clk);
        check("crd_cpu_gnt", cpu_gnt, 32'd1);
        check("crd_ram_we", ram_we, 32'd0);
        exp_cpu(8'hA5);
        tick();
        cpu_req = 1'b0;
        tick();

        // Back-to-back video reads, one per cycle.
        for (int i = 0; i < 4; i++) begin
            vid_req  = 1'b1;
            vid_addr = 10'h100 + 10'(i);
            @(negedge clk);
            check("burst_vid_gnt", vid_gnt, 32'd1);
            exp_vid(8'hC0 + 8'(i));
            tick();
        end
        vid_req = 1'b0;
        tick();

        starve("starve");
        tick();

        // Same-address collision: video reads old data, CPU write lands next.
        vid_req   = 1'b1;
        vid_addr  = 10'h020;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 10'h020;
        cpu_wdata = 8'h22;
        @(negedge clk);
        check("col_vid_gnt", vid_gnt, 32'd1);
        check("col_cpu_gnt", cpu_gnt, 32'd0);
        check("col_ram_we", ram_we, 32'd0);
        exp_vid(8'h11);
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        check("col_cpu_gnt_next", cpu_gnt, 32'd1);
        check("col_ram_we_next", ram_we, 32'd1);
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        vid_req = 1'b1;
        @(negedge clk);
        check("col_reread_gnt", vid_gnt, 32'd1);
        exp_vid(8'h22);
        tick();
        vid_req = 1'b0;
        tick();

        // Reset mid-read with the CPU partway into its wait.
        vid_req  = 1'b1;
        vid_addr = 10'h010;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pre_rst_vid_gnt", vid_gnt, 32'd1);
            exp_vid(8'h5A);
            tick();
        end
        @(negedge clk);
        check("midrst_vid_gnt", vid_gnt, 32'd1);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_vid_rvalid", vid_rvalid, 32'd0);
        check("midrst_cpu_rvalid", cpu_rvalid, 32'd0);
        tick();
        reset = 1'b0;
        starve("post_reset");

        repeat (3) tick();
        check("vid_q_drained", vid_q.size(), 32'd0);
        check("cpu_q_drained", cpu_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous tile/VRAM between two requesters: the video tile fetcher (read-only, deadline-critical) and the CPU (read/write).
- Sits between both requesters and the VRAM instance, which has a 1-cycle registered read and a write on the clock edge.
- Video has fixed priority; a starvation guard bounds CPU wait time.
- Returns read data with a per-requester valid strobe one cycle after grant.

Parameters:
- A, 10, VRAM address width
- D, 8, VRAM data width
- MAX_WAIT, 15, CPU wait cycles before a forced CPU slot; 0 disables the guard (pure video priority)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_req  in  1  video read request; held with vid_addr stable until granted
- vid_addr  in  A  video read address
- vid_gnt  out  1  video access issued this cycle (combinational)
- vid_rvalid  out  1  vid_rdata valid this cycle
- vid_rdata  out  D  video read data
- cpu_req  in  1  CPU request; held with cpu_we/cpu_addr/cpu_wdata stable until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  A  CPU address
- cpu_wdata  in  D  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid this cycle (reads only)
- cpu_rdata  out  D  CPU read data
- ram_addr  out  A  to VRAM addr
- ram_din  out  D  to VRAM din
- ram_we  out  1  to VRAM we
- ram_dout  in  D  from VRAM dout

Behaviour:
- FSM states: VPRIO (reset state) and CFORCE.
- Grant in VPRIO:
  - vid_gnt = vid_req.
  - cpu_gnt = cpu_req & ~vid_req.
- Grant in CFORCE:
  - cpu_gnt = cpu_req.
  - vid_gnt = vid_req & ~cpu_req.
- While reset = 1, both grants are 0 and ram_we = 0.
- Never both grants in one cycle.
- RAM drive (combinational):
  - CPU granted: ram_addr = cpu_addr, ram_din = cpu_wdata, ram_we = cpu_we.
  - Otherwise: ram_addr = vid_addr, ram_din = 0, ram_we = 0.
- Wait counter (width ceil(log2(MAX_WAIT+1)), minimum 1 bit):
  - Increments, saturating at MAX_WAIT, on each cycle with cpu_req & ~cpu_gnt.
  - Clears on cpu_gnt.
  - Clears when cpu_req falls without a grant.
- VPRIO -> CFORCE at the clock edge where the counter equals MAX_WAIT, MAX_WAIT != 0 and cpu_req = 1. The forced grant therefore occurs on the cycle after MAX_WAIT unserved cycles.
- CFORCE -> VPRIO after exactly one cycle, regardless of whether the CPU was granted. If cpu_req drops in that cycle, video is served normally.
- Read return:
  - Registered owner tag owner_q <= {vid_gnt, cpu_gnt & ~cpu_we}.
  - vid_rvalid = owner_q.vid; cpu_rvalid = owner_q.cpu.
  - vid_rdata = cpu_rdata = ram_dout.
  - Latency from grant cycle to rvalid is exactly 1 cycle.
  - Writes produce no rvalid.
- Back-to-back grants to the same requester are allowed every cycle (full throughput, 1 access/cycle).
- Reset values: state VPRIO, counter 0, owner_q 0, so vid_rvalid = cpu_rvalid = 0.
- Reset mid-operation: an in-flight read's rvalid is suppressed if reset is high at the capturing edge. Requesters must re-issue.
- Simultaneous CPU write and video read to the same address: video wins in VPRIO and reads old data; the CPU write lands next cycle.

Decomposition:
- Shared package vram_pkg holds:
  - owner-tag bit positions OWN_VID = 0, OWN_CPU = 1
  - state encoding VPRIO = 1'b0, CFORCE = 1'b1
- The wait counter with its saturation and clear logic is the one natural sub-module: vram_starve_ctr (params W, MAX; ports clk, reset, waiting, served, at_max).
- Everything else stays flat.

Test Plan:
- Idle:
  - Stimulus: no requests for 10 cycles after reset.
  - Required: ram_we = 0, both gnt = 0, both rvalid = 0.
- Video read latency:
  - Stimulus: preload addr 0x010 = 0x5A; vid_req at cycle N with vid_addr 0x010.
  - Required: vid_gnt at N; vid_rvalid at N+1 with vid_rdata = 0x5A; cpu_rvalid = 0.
- CPU write then read:
  - Stimulus: cpu write 0x3FF <- 0xA5 with no video request; then cpu read 0x3FF.
  - Required: ram_we = 1 for exactly one cycle; read returns cpu_rvalid one cycle after grant with 0xA5.
- Starvation guard:
  - Stimulus: MAX_WAIT = 15, vid_req held high continuously, cpu_req raised at cycle N.
  - Required: cpu_gnt first at N+15, vid_gnt = 0 in that cycle, video resumes at N+16.
  - Repeat with MAX_WAIT = 0: cpu_gnt never asserts.
- Same-address collision:
  - Stimulus: addr 0x020 holds 0x11; cpu writes 0x22 to 0x020 while video reads 0x020 in the same cycle.
  - Required: video gets 0x11; a subsequent video read gets 0x22.
- Reset mid-read:
  - Stimulus: grant a video read at N, assert reset at the N/N+1 edge.
  - Required: vid_rvalid = 0 at N+1; state is VPRIO and counter is 0 after reset.
